alu_branch_unit: RTL and testbench

ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

---
 rtl/alu_branch_unit_if.sv | 37 +++
 rtl/alu_branch_unit.sv | 128 ++++++++++++
 tb/tb_alu_branch_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_branch_unit_if.sv
// Bundles the ALU, ID-stage branch and fetch-prediction signals of alu_branch_unit.
// master drives operands and instruction fields; slave returns results and redirects.
interface alu_branch_unit_if;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [5:0]  alu_func;
    logic [15:0] alu_c;
    logic [3:0]  id_op;
    logic [5:0]  id_func;
    logic [11:0] id_imm;
    logic        id_valid;
    logic [15:0] br_src1;
    logic [15:0] br_src2;
    logic [15:0] id_pc;
    logic [15:0] id_pred_next;
    logic [15:0] pc;
    logic [15:0] predicted_next_pc;
    logic        zero;
    logic [15:0] jump_pc;
    logic        jump;
    logic        unconditional_jump;

    modport master (
        output alu_a, alu_b, alu_op, alu_func,
        output id_op, id_func, id_imm, id_valid,
        output br_src1, br_src2, id_pc, id_pred_next, pc,
        input  alu_c, predicted_next_pc, zero, jump_pc, jump, unconditional_jump
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_func,
        input  id_op, id_func, id_imm, id_valid,
        input  br_src1, br_src2, id_pc, id_pred_next, pc,
        output alu_c, predicted_next_pc, zero, jump_pc, jump, unconditional_jump
    );
endinterface

// File: rtl/alu_branch_unit.sv
// 16-bit combinational ALU, ID-stage branch resolution, and a 16-entry
// direct-mapped BTB with 2-bit counters for next-PC prediction.
module alu_branch_unit (
    input logic              clk,
    input logic              reset_n,  // active-high asynchronous reset
    alu_branch_unit_if.slave bus
);

    logic [15:0] w_alu_c;

    always_comb begin
        w_alu_c = '0;
        case (bus.alu_op)
            4'd15: begin
                case (bus.alu_func)
                    6'd0:    w_alu_c = bus.alu_a + bus.alu_b;
                    6'd1:    w_alu_c = bus.alu_a - bus.alu_b;
                    6'd2:    w_alu_c = bus.alu_a & bus.alu_b;
                    6'd3:    w_alu_c = bus.alu_a | bus.alu_b;
                    6'd4:    w_alu_c = ~bus.alu_a;
                    6'd5:    w_alu_c = ~bus.alu_a + 16'd1;
                    6'd6:    w_alu_c = {bus.alu_a[14:0], 1'b0};
                    6'd7:    w_alu_c = {bus.alu_a[15], bus.alu_a[15:1]};
                    6'd28:   w_alu_c = bus.alu_a;
                    default: w_alu_c = '0;
                endcase
            end
            4'd4, 4'd7, 4'd8: w_alu_c = bus.alu_a + bus.alu_b;
            4'd5:             w_alu_c = bus.alu_a | {8'h00, bus.alu_b[7:0]};
            4'd6:             w_alu_c = {bus.alu_b[7:0], 8'h00};
            default:          w_alu_c = '0;
        endcase
    end

    assign bus.alu_c = w_alu_c;

    logic        w_zero;
    logic        w_jr;
    logic        w_cond;
    logic        w_uncond;
    logic        w_ctrl;
    logic [15:0] w_pc_inc;
    logic [15:0] w_br_tgt;
    logic [15:0] w_taken_tgt;
    logic [15:0] w_jump_pc;

    always_comb begin
        w_zero = 1'b0;
        case (bus.id_op)
            4'd0:    w_zero = (bus.br_src1 != bus.br_src2);
            4'd1:    w_zero = (bus.br_src1 == bus.br_src2);
            4'd2:    w_zero = ($signed(bus.br_src1) > 16'sd0);
            4'd3:    w_zero = bus.br_src1[15];
            default: w_zero = 1'b0;
        endcase
    end

    assign w_jr     = (bus.id_op == 4'd15) && ((bus.id_func == 6'd25) || (bus.id_func == 6'd26));
    assign w_cond   = (bus.id_op <= 4'd3);
    assign w_uncond = (bus.id_op == 4'd9) || (bus.id_op == 4'd10) || w_jr;
    assign w_ctrl   = w_cond || w_uncond;
    assign w_pc_inc = bus.id_pc + 16'd1;
    assign w_br_tgt = w_pc_inc + {{8{bus.id_imm[7]}}, bus.id_imm[7:0]};

    // Target if the transfer is taken; non-control ops fall through to pc+1.
    always_comb begin
        w_taken_tgt = w_pc_inc;
        if (w_cond)
            w_taken_tgt = w_br_tgt;
        else if ((bus.id_op == 4'd9) || (bus.id_op == 4'd10))
            w_taken_tgt = {bus.id_pc[15:12], bus.id_imm};
        else if (w_jr)
            w_taken_tgt = bus.br_src1;
    end

    assign w_jump_pc = (w_cond && !w_zero) ? w_pc_inc : w_taken_tgt;

    assign bus.zero               = w_zero;
    assign bus.jump_pc            = w_jump_pc;
    assign bus.jump               = bus.id_valid && (w_jump_pc != bus.id_pred_next);
    assign bus.unconditional_jump = bus.id_valid && w_uncond;

    logic [15:0] r_valid;
    logic [11:0] r_tag    [16];
    logic [15:0] r_target [16];
    logic [1:0]  r_cnt    [16];

    logic [3:0]  w_widx;
    logic        w_whit;
    logic [1:0]  w_cnt_next;

    assign w_widx = bus.id_pc[3:0];
    assign w_whit = r_valid[w_widx] && (r_tag[w_widx] == bus.id_pc[15:4]);

    always_comb begin
        w_cnt_next = 2'd1;
        if (w_uncond)
            w_cnt_next = 2'd3;
        else if (w_whit)
            w_cnt_next = w_zero ? ((r_cnt[w_widx] == 2'd3) ? 2'd3 : r_cnt[w_widx] + 2'd1)
                                : ((r_cnt[w_widx] == 2'd0) ? 2'd0 : r_cnt[w_widx] - 2'd1);
        else
            w_cnt_next = w_zero ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_valid  <= '0;
            r_tag    <= '{default: '0};
            r_target <= '{default: '0};
            r_cnt    <= '{default: 2'd1};
        end else if (bus.id_valid && w_ctrl) begin
            r_valid[w_widx]  <= 1'b1;
            r_tag[w_widx]    <= bus.id_pc[15:4];
            r_target[w_widx] <= w_taken_tgt;
            r_cnt[w_widx]    <= w_cnt_next;
        end
    end

    logic [3:0] w_pidx;
    logic       w_phit;

    assign w_pidx = bus.pc[3:0];
    assign w_phit = r_valid[w_pidx] && (r_tag[w_pidx] == bus.pc[15:4]) && (r_cnt[w_pidx] >= 2'd2);

    assign bus.predicted_next_pc = w_phit ? r_target[w_pidx] : bus.pc + 16'd1;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed and randomized checks of alu_branch_unit against a behavioural
// model of the ALU, branch rules and BTB predictor.
module tb_alu_branch_unit;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    alu_branch_unit_if bus ();

    alu_branch_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        int       tag;
        int       target;
        int       cnt;
    } btb_entry_t;

    btb_entry_t m_btb [16];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        foreach (m_btb[i]) begin
            m_btb[i].v      = 1'b0;
            m_btb[i].tag    = 0;
            m_btb[i].target = 0;
            m_btb[i].cnt    = 1;
        end
    endfunction

    function automatic logic [15:0] m_alu(input int op, input int func, input int a, input int b);
        int r;
        r = 0;
        if (op == 15) begin
            case (func)
                0:  r = a + b;
                1:  r = a - b;
                2:  r = a & b;
                3:  r = a | b;
                4:  r = 65535 - a;
                5:  r = 65536 - a;
                6:  r = a * 2;
                7:  r = (a >= 32768) ? (a / 2 + 32768) : (a / 2);
                28: r = a;
                default: r = 0;
            endcase
        end else if (op == 4 || op == 7 || op == 8) r = a + b;
        else if (op == 5) r = a | (b % 256);
        else if (op == 6) r = (b % 256) * 256;
        return 16'(r % 65536);
    endfunction

    function automatic int as_signed(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic bit m_zero(input int op, input int s1, input int s2);
        case (op)
            0: return s1 != s2;
            1: return s1 == s2;
            2: return as_signed(s1) > 0;
            3: return as_signed(s1) < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_is_jr(input int op, input int func);
        return op == 15 && (func == 25 || func == 26);
    endfunction

    function automatic bit m_is_uncond(input int op, input int func);
        return op == 9 || op == 10 || m_is_jr(op, func);
    endfunction

    function automatic bit m_is_ctrl(input int op, input int func);
        return op <= 3 || m_is_uncond(op, func);
    endfunction

    function automatic int m_taken_target(input int op, input int func, input int imm,
                                          input int idpc, input int s1);
        int off;
        if (op <= 3) begin
            off = imm % 256;
            if (off >= 128) off -= 256;
            return (idpc + 1 + off + 65536) % 65536;
        end
        if (op == 9 || op == 10) return (idpc / 4096) * 4096 + imm;
        if (m_is_jr(op, func)) return s1;
        return (idpc + 1) % 65536;
    endfunction

    function automatic int m_jump_pc(input int op, input int func, input int imm,
                                     input int idpc, input int s1, input int s2);
        if (op <= 3 && !m_zero(op, s1, s2)) return (idpc + 1) % 65536;
        return m_taken_target(op, func, imm, idpc, s1);
    endfunction

    function automatic int m_predict(input int p);
        int i;
        i = p % 16;
        if (m_btb[i].v && m_btb[i].tag == p / 16 && m_btb[i].cnt >= 2) return m_btb[i].target;
        return (p + 1) % 65536;
    endfunction

    function automatic void m_commit(input bit valid, input int op, input int func, input int imm,
                                     input int idpc, input int s1, input int s2);
        int  i;
        bit  hit;
        bit  tk;
        if (!(valid && m_is_ctrl(op, func))) return;
        i   = idpc % 16;
        hit = m_btb[i].v && m_btb[i].tag == idpc / 16;
        tk  = m_zero(op, s1, s2);
        if (m_is_uncond(op, func)) m_btb[i].cnt = 3;
        else if (hit) m_btb[i].cnt = tk ? ((m_btb[i].cnt < 3) ? m_btb[i].cnt + 1 : 3)
                                        : ((m_btb[i].cnt > 0) ? m_btb[i].cnt - 1 : 0);
        else m_btb[i].cnt = tk ? 2 : 1;
        m_btb[i].v      = 1'b1;
        m_btb[i].tag    = idpc / 16;
        m_btb[i].target = m_taken_target(op, func, imm, idpc, s1);
    endfunction

    task automatic set_id(input bit valid, input logic [3:0] op, input logic [5:0] func,
                          input logic [11:0] imm, input logic [15:0] idpc,
                          input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] pn);
        bus.id_valid     = valid;
        bus.id_op        = op;
        bus.id_func      = func;
        bus.id_imm       = imm;
        bus.id_pc        = idpc;
        bus.br_src1      = s1;
        bus.br_src2      = s2;
        bus.id_pred_next = pn;
    endtask

    task automatic alu_case(input string tag, input logic [3:0] op, input logic [5:0] func,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        bus.alu_op   = op;
        bus.alu_func = func;
        bus.alu_a    = a;
        bus.alu_b    = b;
        #1;
        chk(tag, bus.alu_c, exp);
    endtask

    logic [11:0] tags [3];

    initial begin
        total = 0;
        bad   = 0;
        tags[0] = 12'h002;
        tags[1] = 12'h300;
        tags[2] = 12'hFFF;
        m_reset();

        reset_n = 1'b1;
        bus.alu_a = '0; bus.alu_b = '0; bus.alu_op = '0; bus.alu_func = '0;
        bus.pc = 16'h0020;
        set_id(1'b0, 4'd4, 6'd0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #2;
        chk("reset_pred", bus.predicted_next_pc, 16'h0021);
        chk("reset_jump", {15'b0, bus.jump}, 16'h0000);
        step();
        reset_n = 1'b0;
        #1;

        alu_case("alu_add_wrap", 4'd15, 6'd0, 16'h7FFF, 16'h0001, 16'h8000);
        alu_case("alu_neg",      4'd15, 6'd5, 16'h0003, 16'h0000, 16'hFFFD);
        alu_case("alu_asr",      4'd15, 6'd7, 16'h8002, 16'h0000, 16'hC001);
        alu_case("alu_lhi",      4'd6,  6'd0, 16'h0000, 16'hFF12, 16'h1200);
        alu_case("alu_ori",      4'd5,  6'd0, 16'h0100, 16'hFFF0, 16'h01F0);
        alu_case("alu_sub",      4'd15, 6'd1, 16'h0000, 16'h0001, 16'hFFFF);
        alu_case("alu_wwd",      4'd15, 6'd28, 16'hBEEF, 16'h1234, 16'hBEEF);
        alu_case("alu_badfunc",  4'd15, 6'd9, 16'hBEEF, 16'h1234, 16'h0000);
        alu_case("alu_badop",    4'd12, 6'd0, 16'hBEEF, 16'h1234, 16'h0000);

        set_id(1'b0, 4'd2, 6'd0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000); #1;
        chk("bgz_zero", {15'b0, bus.zero}, 16'h0000);
        set_id(1'b0, 4'd3, 6'd0, 12'h000, 16'h0000, 16'h8000, 16'h0000, 16'h0000); #1;
        chk("blz_neg", {15'b0, bus.zero}, 16'h0001);
        set_id(1'b0, 4'd0, 6'd0, 12'h000, 16'h0000, 16'h1234, 16'h1234, 16'h0000); #1;
        chk("bne_eq", {15'b0, bus.zero}, 16'h0000);
        set_id(1'b0, 4'd1, 6'd0, 12'h000, 16'h0000, 16'h1234, 16'h1234, 16'h0000); #1;
        chk("beq_eq", {15'b0, bus.zero}, 16'h0001);
        chk("jump_invalid", {15'b0, bus.jump}, 16'h0000);

        bus.pc = 16'hFFFF; #1;
        chk("pred_wrap", bus.predicted_next_pc, 16'h0000);
        bus.pc = 16'h0020;

        set_id(1'b1, 4'd1, 6'd0, 12'h005, 16'h0020, 16'h0007, 16'h0007, 16'h0021); #1;
        chk("beq_tk_jpc", bus.jump_pc, 16'h0026);
        chk("beq_tk_jump", {15'b0, bus.jump}, 16'h0001);
        chk("beq_tk_unc", {15'b0, bus.unconditional_jump}, 16'h0000);
        chk("beq_tk_same_cycle_pred", bus.predicted_next_pc, 16'h0021);
        step();
        set_id(1'b0, 4'd4, 6'd0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000); #1;
        chk("pred_after_tk", bus.predicted_next_pc, 16'h0026);

        set_id(1'b1, 4'd1, 6'd0, 12'h005, 16'h0020, 16'h0001, 16'h0002, 16'h0026); #1;
        chk("beq_nt1_jpc", bus.jump_pc, 16'h0021);
        chk("beq_nt1_jump", {15'b0, bus.jump}, 16'h0001);
        step();
        chk("pred_cnt1", bus.predicted_next_pc, 16'h0021);
        set_id(1'b1, 4'd1, 6'd0, 12'h005, 16'h0020, 16'h0001, 16'h0002, 16'h0021); #1;
        chk("beq_nt2_jump", {15'b0, bus.jump}, 16'h0000);
        step();
        chk("pred_cnt0", bus.predicted_next_pc, 16'h0021);
        set_id(1'b1, 4'd1, 6'd0, 12'h005, 16'h0020, 16'h0003, 16'h0003, 16'h0021); step();
        chk("pred_cnt0_to_1", bus.predicted_next_pc, 16'h0021);
        step();
        chk("pred_cnt1_to_2", bus.predicted_next_pc, 16'h0026);

        set_id(1'b1, 4'd9, 6'd0, 12'hABC, 16'h3005, 16'h0000, 16'h0000, 16'h3006); #1;
        chk("jmp_jpc", bus.jump_pc, 16'h3ABC);
        chk("jmp_unc", {15'b0, bus.unconditional_jump}, 16'h0001);
        step();
        set_id(1'b0, 4'd4, 6'd0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        bus.pc = 16'h3005; #1;
        chk("pred_jmp_hit", bus.predicted_next_pc, 16'h3ABC);
        bus.pc = 16'h0015; #1;
        chk("pred_tag_miss", bus.predicted_next_pc, 16'h0016);
        bus.pc = 16'h0020; #1;
        chk("pred_before_rst", bus.predicted_next_pc, 16'h0026);

        reset_n = 1'b1; #1;
        chk("async_rst_pred", bus.predicted_next_pc, 16'h0021);
        set_id(1'b1, 4'd1, 6'd0, 12'h005, 16'h0020, 16'h0007, 16'h0007, 16'h0021);
        step(); step();
        reset_n = 1'b0;
        set_id(1'b0, 4'd4, 6'd0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000); #1;
        chk("no_upd_in_rst", bus.predicted_next_pc, 16'h0021);
        m_reset();

        for (int n = 0; n < 400; n++) begin
            int op, func, imm, idpc, s1, s2, pn, ap, af;
            bit vld;
            ap = (($urandom_range(0, 2) == 0)) ? 15 : $urandom_range(0, 15);
            af = (($urandom_range(0, 5) == 0)) ? 28 : $urandom_range(0, 9);
            bus.alu_op   = 4'(ap);
            bus.alu_func = 6'(af);
            bus.alu_a    = 16'($urandom);
            bus.alu_b    = 16'($urandom);
            case ($urandom_range(0, 7))
                0, 1, 2, 3: begin op = $urandom_range(0, 3); func = $urandom_range(0, 63); end
                4:          begin op = 9 + $urandom_range(0, 1); func = $urandom_range(0, 63); end
                5:          begin op = 15; func = 25 + $urandom_range(0, 1); end
                default:    begin op = $urandom_range(0, 15); func = $urandom_range(0, 63); end
            endcase
            imm  = $urandom_range(0, 4095);
            idpc = tags[$urandom_range(0, 2)] * 16 + $urandom_range(0, 3);
            s1   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 65535);
            s2   = ($urandom_range(0, 2) == 0) ? s1 : $urandom_range(0, 65535);
            vld  = ($urandom_range(0, 4) != 0);
            pn   = ($urandom_range(0, 1) == 0) ? m_predict(idpc) : $urandom_range(0, 65535);
            set_id(vld, 4'(op), 6'(func), 12'(imm), 16'(idpc), 16'(s1), 16'(s2), 16'(pn));
            bus.pc = 16'(tags[$urandom_range(0, 2)] * 16 + $urandom_range(0, 3));
            #1;
            chk("rnd_alu", bus.alu_c, m_alu(ap, af, bus.alu_a, bus.alu_b));
            chk("rnd_zero", {15'b0, bus.zero}, {15'b0, m_zero(op, s1, s2)});
            chk("rnd_jpc", bus.jump_pc, 16'(m_jump_pc(op, func, imm, idpc, s1, s2)));
            chk("rnd_jump", {15'b0, bus.jump},
                {15'b0, vld && (m_jump_pc(op, func, imm, idpc, s1, s2) != pn)});
            chk("rnd_unc", {15'b0, bus.unconditional_jump}, {15'b0, vld && m_is_uncond(op, func)});
            chk("rnd_pred", bus.predicted_next_pc, 16'(m_predict(int'(bus.pc))));
            m_commit(vld, op, func, imm, idpc, s1, s2);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
